// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; dout is registered one cycle
// behind the FSM state, so the start bit appears two cycles after the write.
module uart_tx #(
  parameter int BAUD       = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       rdy,
  output logic       dout,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [12:0]   BAUD_LAST = 13'(BAUD - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  state_t        state;
  state_t        next_state;
  logic [12:0]   baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic          push;
  logic          pop;
  logic          baud_wrap;

  // Handshake: a byte is taken on every cycle where din_vld and rdy are both
  // high; rdy is registered, so a full FIFO refuses even when a pop coincides.
  always_comb begin
    baud_wrap  = (baud_cnt == BAUD_LAST);
    push       = din_vld && rdy;
    pop        = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: if (baud_wrap) next_state = DATA;
      DATA:  if (baud_wrap && bit_cnt == 3'd7) next_state = STOP;
      STOP: begin
        if (baud_wrap) begin
          if (count != '0) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    next_count = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout     <= 1'b1;
      rdy      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= next_count;
      rdy   <= (next_count < DEPTH_C);
      busy  <= (next_state != IDLE) || (next_count != '0);
      state <= next_state;

      // Baud counter restarts on every state change and idles at zero.
      if (state == IDLE || next_state != state || baud_wrap) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 13'd1;
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (baud_wrap) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (pop) begin
        shift <= mem[rd_ptr];
      end else if (state == DATA && baud_wrap) begin
        shift <= {1'b0, shift[7:1]};
      end

      case (state)
        START:   dout <= 1'b0;
        DATA:    dout <= shift[0];
        default: dout <= 1'b1;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD, default 434, meaning clock cycles per serial bit (50 MHz / 115200); legal range 4..8191.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning byte-buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  8  byte to transmit.
REQ-006 SHALL have port din_vld  input  1  write strobe for din; one byte per high cycle.
REQ-007 SHALL have port rdy  output  1  high when the buffer can accept a byte.
REQ-008 SHALL have port dout  output  1  serial line; idle high; registered.
REQ-009 SHALL have port busy  output  1  high while a frame is on the line or the buffer is non-empty.

Function
REQ-010 SHALL send frame format 8N1: start bit 0, data bits 0..7 LSB first, one stop bit 1; each bit held exactly BAUD cycles; frame = 10*BAUD cycles.
REQ-011 SHALL buffer bytes in a FIFO_DEPTH-entry FIFO; a write occurs on any cycle with din_vld=1 and rdy=1.
REQ-012 SHALL drive rdy = 1 when FIFO count < FIFO_DEPTH, registered, updated the cycle after each push/pop.
REQ-013 SHALL drop din_vld while rdy=0, with no state change; a push and pop in the same cycle while full is still refused.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: dout=1; if FIFO non-empty, pop head into shift register and go to START.
REQ-016 START: dout=0 for BAUD cycles, then DATA.
REQ-017 DATA: shift out 8 bits, bit counter 0..7, advance on baud counter wrap (BAUD-1 -> 0); after bit 7 go to STOP.
REQ-018 STOP: dout=1 for BAUD cycles; at end, if FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
REQ-019 Latency: with IDLE and FIFO empty, din_vld high in cycle N makes dout fall at the edge ending cycle N+2.
REQ-020 Baud counter SHALL be 13 bits, count only outside IDLE, and clear on every state change.
REQ-021 din changes after the write cycle SHALL NOT affect the frame being sent or already buffered bytes.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-023 busy SHALL be 1 whenever state != IDLE or count != 0, registered, same timing as rdy.

Reset
REQ-024 rst_n=0 sampled on a clk edge SHALL force: state IDLE, dout=1, rdy=1, busy=0, counters 0, FIFO empty, pointers 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; dout=1 from the first edge after reset sampled low; buffered bytes discarded.
REQ-026 din_vld during reset SHALL be ignored.

Verification (BAUD=8, FIFO_DEPTH=4 unless noted)
REQ-027 Single byte 0xA5 into idle block -> dout low 2 cycles after write, line sequence 0,1,0,1,0,0,1,0,1,1 each 8 cycles, busy low after 80+ cycles.
REQ-028 Five writes back-to-back (0x01..0x05) while first frame starts -> 0x01..0x05 sent contiguously, no idle gap between stop and next start; rdy low only while 4 bytes are buffered.
REQ-029 Fill buffer while transmitting, then extra write 0xFF with rdy=0 -> 0xFF never appears on dout; count stays 4.
REQ-030 Reset pulse in DATA bit 3 of 0x3C -> dout=1 next edge, rdy=1, busy=0; a following write of 0x81 transmits cleanly.
REQ-031 Default BAUD=434, byte 0x00 -> start plus 8 zero bits = 3906 low cycles, then 434 high stop cycles.
REQ-032 Loopback dout into the team's uart receiver with matching BAUD, random 256 bytes -> every byte received in order, no dropped or corrupted byte.
